// File: rtl/mips_alu.sv
// Execute-stage MIPS ALU: arithmetic, logic, compare, shift and LUI with status flags.
// Every output is registered, so a result appears one clock after its operands and opcode.
module mips_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       aluc,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             flag
);

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_ADDU = 6'b100001;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_SUBU = 6'b100011;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;
  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_SLLV = 6'b000100;
  localparam logic [5:0] OP_SRLV = 6'b000110;
  localparam logic [5:0] OP_SRAV = 6'b000111;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_LUI  = 6'b001111;

  logic [4:0]       shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shlExt;
  logic [WIDTH:0]   shrExt;
  logic [WIDTH:0]   sraExt;
  logic             sltSigned;

  logic [WIDTH-1:0] r_d, r_q;
  logic             zero_d, zero_q;
  logic             carry_d, carry_q;
  logic             negative_d, negative_q;
  logic             overflow_d, overflow_q;
  logic             flag_d, flag_q;

  assign shamt     = a[4:0];
  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign sltSigned = $signed(a) < $signed(b);

  // Shifts run on a one-bit-extended copy of b so the last bit shifted out lands in the
  // extension bit; with a zero shift amount that bit stays 0, giving carry=0 for free.
  assign shlExt = {1'b0, b} << shamt;
  assign shrExt = {b, 1'b0} >> shamt;
  assign sraExt = $signed({b, 1'b0}) >>> shamt;

  always_comb begin
    r_d        = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    flag_d     = 1'b0;
    unique case (aluc)
      OP_ADD: begin
        r_d        = sum[WIDTH-1:0];
        overflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDU: begin
        r_d     = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
      end
      OP_SUB: begin
        r_d        = diff[WIDTH-1:0];
        overflow_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUBU: begin
        r_d     = diff[WIDTH-1:0];
        carry_d = diff[WIDTH];
      end
      OP_AND: r_d = a & b;
      OP_OR:  r_d = a | b;
      OP_XOR: r_d = a ^ b;
      OP_NOR: r_d = ~(a | b);
      OP_SLT: begin
        r_d    = {{(WIDTH-1){1'b0}}, sltSigned};
        flag_d = sltSigned;
      end
      OP_SLTU: begin
        r_d     = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
        flag_d  = diff[WIDTH];
        carry_d = diff[WIDTH];
      end
      OP_SLL, OP_SLLV: begin
        r_d     = shlExt[WIDTH-1:0];
        carry_d = shlExt[WIDTH];
      end
      OP_SRL, OP_SRLV: begin
        r_d     = shrExt[WIDTH:1];
        carry_d = shrExt[0];
      end
      OP_SRA, OP_SRAV: begin
        r_d     = sraExt[WIDTH:1];
        carry_d = sraExt[0];
      end
      OP_JR:  r_d = a;
      OP_LUI: r_d = {b[15:0], {(WIDTH-16){1'b0}}};
      default: r_d = '0;
    endcase
    zero_d     = (r_d == '0);
    negative_d = r_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      r_q        <= r_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
      flag_q     <= flag_d;
    end
  end

  assign r        = r_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign negative = negative_q;
  assign overflow = overflow_q;
  assign flag     = flag_q;

endmodule

// File: tb/tb_mips_alu.sv
// Directed bench for mips_alu: expected results are queued when stimulus is driven and
// popped one clock later, with r checked against fixed values and flags against a model.
module tb_mips_alu;

  localparam logic [5:0] ADD  = 6'b100000, ADDU = 6'b100001, SUB  = 6'b100010, SUBU = 6'b100011;
  localparam logic [5:0] AND_ = 6'b100100, OR_  = 6'b100101, XOR_ = 6'b100110, NOR_ = 6'b100111;
  localparam logic [5:0] SLT  = 6'b101010, SLTU = 6'b101011, SLL  = 6'b000000, SRL  = 6'b000010;
  localparam logic [5:0] SRA  = 6'b000011, SLLV = 6'b000100, SRLV = 6'b000110, SRAV = 6'b000111;
  localparam logic [5:0] JR   = 6'b001000, LUI  = 6'b001111, BAD  = 6'b111111;

  typedef struct {
    string       tag;
    logic [31:0] r;
    logic        z, c, n, v, f;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [5:0]  aluc = ADD;
  logic [31:0] r;
  logic        zero, carry, negative, overflow, flag;

  int   compared = 0;
  int   mismatched = 0;
  exp_t sb[$];

  mips_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .aluc(aluc),
    .r(r), .zero(zero), .carry(carry), .negative(negative), .overflow(overflow), .flag(flag)
  );

  always #5 clk = ~clk;

  // Independent reference: 64-bit arithmetic for flags, bit-at-a-time loops for shifts.
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic [5:0] op);
    exp_t   e;
    longint sa, sb2, ua, ub, res;
    int     s;
    e.tag = ""; e.r = '0; e.c = 1'b0; e.v = 1'b0; e.f = 1'b0;
    sa  = longint'($signed(av));
    sb2 = longint'($signed(bv));
    ua  = longint'({32'h0, av});
    ub  = longint'({32'h0, bv});
    s   = int'(av[4:0]);
    case (op)
      ADD:  begin res = sa + sb2; e.r = av + bv; e.v = (res > 64'sd2147483647) || (res < -64'sd2147483648); end
      ADDU: begin res = ua + ub;  e.r = av + bv; e.c = (res >= 64'sd4294967296); end
      SUB:  begin res = sa - sb2; e.r = av - bv; e.v = (res > 64'sd2147483647) || (res < -64'sd2147483648); end
      SUBU: begin e.r = av - bv; e.c = (ua < ub); end
      AND_: e.r = av & bv;
      OR_:  e.r = av | bv;
      XOR_: e.r = av ^ bv;
      NOR_: e.r = ~(av | bv);
      SLT:  begin e.f = (sa < sb2); e.r = {31'b0, e.f}; end
      SLTU: begin e.f = (ua < ub); e.c = e.f; e.r = {31'b0, e.f}; end
      SLL, SLLV: begin e.r = bv; for (int i = 0; i < s; i++) begin e.c = e.r[31]; e.r = {e.r[30:0], 1'b0}; end end
      SRL, SRLV: begin e.r = bv; for (int i = 0; i < s; i++) begin e.c = e.r[0]; e.r = {1'b0, e.r[31:1]}; end end
      SRA, SRAV: begin e.r = bv; for (int i = 0; i < s; i++) begin e.c = e.r[0]; e.r = {e.r[31], e.r[31:1]}; end end
      JR:   e.r = av;
      LUI:  e.r = {bv[15:0], 16'h0000};
      default: e.r = '0;
    endcase
    e.z = (e.r == 32'h0);
    e.n = e.r[31];
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one operation at the falling edge and queue what should appear after the next rise.
  task automatic applyStimulus(input string tag, input logic [31:0] av, input logic [31:0] bv,
                               input logic [5:0] op, input logic [31:0] planR);
    exp_t e;
    @(negedge clk);
    a = av; b = bv; aluc = op;
    e = model(av, bv, op);
    e.tag = tag;
    e.r = planR;
    sb.push_back(e);
    @(posedge clk);
    #1;
    popAndCompare();
  endtask

  task automatic popAndCompare();
    exp_t e;
    compared++;
    assert (sb.size() != 0) else begin
      mismatched++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    checkOutput({e.tag, ".r"},        r,               e.r);
    checkOutput({e.tag, ".zero"},     {31'b0, zero},     {31'b0, e.z});
    checkOutput({e.tag, ".carry"},    {31'b0, carry},    {31'b0, e.c});
    checkOutput({e.tag, ".negative"}, {31'b0, negative}, {31'b0, e.n});
    checkOutput({e.tag, ".overflow"}, {31'b0, overflow}, {31'b0, e.v});
    checkOutput({e.tag, ".flag"},     {31'b0, flag},     {31'b0, e.f});
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".r"}, r, 32'h0);
    checkOutput({tag, ".flags"}, {26'b0, zero, carry, negative, overflow, flag}, 32'h0);
  endtask

  initial begin
    exp_t e;
    $display("[TB] starting mips_alu bench");

    // Load a nonzero result so the asynchronous reset has something to clear.
    applyStimulus("pre_add", 32'h1c, 32'h21, ADD, 32'h3d);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkAllZero("reset_async");
    @(posedge clk); #1 checkAllZero("reset_held");
    @(negedge clk) rst_n = 1'b1;

    applyStimulus("ADD",  32'h1c, 32'h21, ADD,  32'h3d);
    applyStimulus("ADDU", 32'h1c, 32'h21, ADDU, 32'h3d);
    applyStimulus("SUB",  32'h1c, 32'h21, SUB,  32'hfffffffb);
    applyStimulus("SUBU", 32'h1c, 32'h21, SUBU, 32'hfffffffb);
    applyStimulus("AND",  32'h1c, 32'h21, AND_, 32'h0);
    applyStimulus("OR",   32'h1c, 32'h21, OR_,  32'h3d);
    applyStimulus("XOR",  32'h1c, 32'h21, XOR_, 32'h3d);
    applyStimulus("NOR",  32'h1c, 32'h21, NOR_, 32'hffffffc2);
    applyStimulus("SLT",  32'h1c, 32'h21, SLT,  32'h1);
    applyStimulus("SLTU", 32'h1c, 32'h21, SLTU, 32'h1);
    applyStimulus("SLL",  32'h1c, 32'h21, SLL,  32'h10000000);
    applyStimulus("SRL",  32'h1c, 32'h21, SRL,  32'h0);
    applyStimulus("SRA",  32'h1c, 32'h21, SRA,  32'h0);
    applyStimulus("SLLV", 32'h1c, 32'h21, SLLV, 32'h10000000);
    applyStimulus("SRLV", 32'h1c, 32'h21, SRLV, 32'h0);
    applyStimulus("SRAV", 32'h1c, 32'h21, SRAV, 32'h0);
    applyStimulus("LUI",  32'h1c, 32'h21, LUI,  32'h00210000);

    applyStimulus("ADD_ovf",   32'h7fffffff, 32'h1, ADD,  32'h80000000);
    applyStimulus("ADDU_cout", 32'hffffffff, 32'h1, ADDU, 32'h0);
    applyStimulus("SUB_ovf",   32'h80000000, 32'h1, SUB,  32'h7fffffff);
    applyStimulus("SLT_sign",  32'hffffffff, 32'h1, SLT,  32'h1);
    applyStimulus("SLTU_sign", 32'hffffffff, 32'h1, SLTU, 32'h0);
    applyStimulus("SRA_neg",   32'h4, 32'h80000010, SRA, 32'hf8000001);
    applyStimulus("SRL_neg",   32'h4, 32'h80000010, SRL, 32'h08000001);
    applyStimulus("SLL_cout",  32'h1, 32'h80000001, SLL, 32'h00000002);
    applyStimulus("SRL_cout",  32'h3, 32'h0000000c, SRLV, 32'h00000001);
    applyStimulus("SLL_hiA",   32'hffffffe4, 32'h1, SLLV, 32'h10);
    applyStimulus("SRA_s0",    32'hffffffe0, 32'h80000001, SRAV, 32'h80000001);
    applyStimulus("JR",        32'hdeadbeef, 32'h1, JR, 32'hdeadbeef);
    applyStimulus("BAD",       32'h1c, 32'h21, BAD, 32'h0);

    // Latency: an opcode change between edges must not reach r until the next rise.
    applyStimulus("lat_and", 32'h1c, 32'h21, AND_, 32'h0);
    @(negedge clk);
    aluc = OR_;
    e = model(32'h1c, 32'h21, OR_);
    e.tag = "lat_or";
    e.r = 32'h3d;
    sb.push_back(e);
    #1 checkOutput("lat_hold.r", r, 32'h0);
    @(posedge clk); #1 popAndCompare();

    // Reset asserted while a capture is pending wins over it.
    @(negedge clk);
    a = 32'h7fffffff; b = 32'h1; aluc = ADD;
    #1 rst_n = 1'b0;
    #1 checkAllZero("reset_mid");
    @(posedge clk); #1 checkAllZero("reset_mid_edge");
    @(negedge clk) rst_n = 1'b1;
    applyStimulus("post_reset", 32'h7fffffff, 32'h1, ADD, 32'h80000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- 32-bit MIPS-style integer ALU; operation selected by a 6-bit funct-style code `aluc`.
- Sits in the execute stage of the datapath.
- Computes arithmetic, logic, compare, shift and LUI results plus status flags.
- All outputs are registered: one clock of latency from operand/op change to the result.

Parameters:
- WIDTH, 32, operand/result width (only 32 is required to be supported).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  32  operand A; also the shift amount source (a[4:0])
- b  input  32  operand B; the value that is shifted, and the LUI source
- aluc  input  6  operation code
- r  output  32  registered result
- zero  output  1  registered; 1 when the computed result is 0
- carry  output  1  registered carry/borrow/shift-out flag
- negative  output  1  registered; equals the result's bit 31
- overflow  output  1  registered signed overflow flag
- flag  output  1  registered compare flag; defined for SLT/SLTU only

Behaviour:
- Reset (rst_n low, asynchronous): r=0, zero=0, carry=0, negative=0, overflow=0, flag=0. Outputs hold these values until the first rising clk after rst_n is released.
- Each rising clk: the combinational result for the current a, b, aluc is captured into all outputs. Latency is exactly 1 cycle; there is no handshake.
- Opcodes (aluc, binary), with s = a[4:0]:
  - ADD 100000: r=a+b; overflow = signed overflow.
  - ADDU 100001: r=a+b; carry = bit-32 carry-out.
  - SUB 100010: r=a-b; overflow = signed overflow.
  - SUBU 100011: r=a-b; carry = borrow (a<b unsigned).
  - AND 100100: r=a&b.
  - OR 100101: r=a|b.
  - XOR 100110: r=a^b.
  - NOR 100111: r=~(a|b).
  - SLT 101010: r = (signed a < signed b) ? 1 : 0; flag = r[0].
  - SLTU 101011: r = (unsigned a < unsigned b) ? 1 : 0; flag = r[0]; carry = r[0].
  - SLL 000000 and SLLV 000100: r = b << s.
  - SRL 000010 and SRLV 000110: r = b >> s (logical).
  - SRA 000011 and SRAV 000111: r = b >>> s (arithmetic, sign of b[31] fills).
  - Shift carry: carry = last bit shifted out when s!=0; carry=0 when s=0.
  - JR 001000: r=a (pass-through).
  - LUI 001111: r = {b[15:0], 16'h0000}.
- Flag rules that apply to every opcode:
  - zero = (r==0).
  - negative = r[31].
  - overflow = 0 except for ADD/SUB.
  - carry = 0 except where defined above.
  - flag = 0 except for SLT/SLTU.
- Any other aluc: r=0, zero=1, all other flags 0.
- Shift-amount width: bits a[31:5] are ignored for all shifts; s=0 leaves b unchanged.
- Arithmetic wrap-around: results are modulo 2^32; overflow/carry are flags only and never trap.
- Reset mid-operation: asynchronous reset overrides any pending capture. The first valid result appears on the first rising edge after rst_n goes high.

Test Plan:
- Reset: assert rst_n=0 with a=0x1c, b=0x21, aluc=ADD -> all outputs 0 immediately, without waiting for a clock edge.
- Operand pair a=0x1c, b=0x21; step aluc one code per cycle and check r one cycle later, in this order:
  - ADD 0x3d
  - ADDU 0x3d
  - SUB 0xfffffffb
  - SUBU 0xfffffffb
  - AND 0x0 (zero=1)
  - OR 0x3d
  - XOR 0x3d
  - NOR 0xffffffc2
  - SLT 0x1
  - SLTU 0x1
  - SLL 0x10000000
  - SRL 0x0
  - SRA 0x0
  - SLLV 0x10000000
  - SRLV 0x0
  - SRAV 0x0
  - LUI 0x00210000
- Overflow: ADD a=0x7fffffff, b=1 -> r=0x80000000, overflow=1, negative=1. ADDU a=0xffffffff, b=1 -> r=0, carry=1, zero=1.
- Compare signedness: a=0xffffffff, b=1 -> SLT gives r=1, flag=1; SLTU gives r=0, flag=0.
- Arithmetic shift: SRA a=4, b=0x80000010 -> r=0xf8000001, carry=0. SRL with the same operands -> r=0x08000001.
- Latency: change aluc from AND to OR between edges -> r updates only at the next rising clk. An unknown code (e.g. 111111) -> r=0, zero=1.
